cpu_sequencer: RTL and testbench

Multi-cycle control sequencer for the EyeArch core. Steps every instruction through fetch, decode, execute, memory and writeback states, and drives the strobes for the PC, instruction register, register file, ALU and data-memory port. Decode stays combinational in `cu`: it reduces the opcode to an instruction class, and `cpu_sequencer` decides in which cycle each strobe fires. It also owns the data-memory request/ready handshake, with a timeout.

---
 rtl/eyearch_pkg.sv | 33 +++
 rtl/seq_perf_cnt.sv | 23 ++
 rtl/cpu_sequencer.sv | 152 +++++++++++++++
 tb/tb_cpu_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/eyearch_pkg.sv
// Shared types for the EyeArch control path.
// State and instruction-class encodings used by cu and cpu_sequencer.
package eyearch_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } seq_state_t;

  typedef enum logic [2:0] {
    IC_NOP    = 3'd0,
    IC_ALU    = 3'd1,
    IC_LOAD   = 3'd2,
    IC_STORE  = 3'd3,
    IC_BRANCH = 3'd4,
    IC_HALT   = 3'd5
  } inst_class_t;

  // Reserved class codes behave as NOP.
  function automatic inst_class_t norm_class(
    input logic [2:0] c
  );
    if (c > 3'd5) return IC_NOP;
    return inst_class_t'(c);
  endfunction

endpackage

// File: rtl/seq_perf_cnt.sv
// Cycle and retirement counters for the sequencer.
// Built only when SEQ_PERF_CNT_EN is defined.
module seq_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        active,
  input  logic        retire,
  output logic [31:0] cycle_cnt,
  output logic [31:0] retired_cnt
);

  // Free-running counters, wrap at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      retired_cnt <= '0;
    end else begin
      if (active) cycle_cnt <= cycle_cnt + 32'd1;
      if (retire) retired_cnt <= retired_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: FSM, strobes, memory timeout.
// Optional perf counters under SEQ_PERF_CNT_EN.
module cpu_sequencer
  import eyearch_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [2:0] inst_class,
  input  logic       cond_true,
  input  logic       mem_ready,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       reg_read,
  output logic       alu_enable,
  output logic       reg_write,
  output logic       mem_req,
  output logic       mem_we,
  output logic       halted,
  output logic       fault,
  output logic [2:0] state
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] retired_cnt
`endif
);

  localparam int CW =
    (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO_LAST =
    CW'(MEM_TIMEOUT - 1);

  seq_state_t  st_q;
  seq_state_t  st_d;
  inst_class_t cls_q;
  inst_class_t dec_cls;
  logic [CW-1:0] tmo_q;
  logic        tmo_hit;

  assign dec_cls = norm_class(inst_class);
  assign tmo_hit = (MEM_TIMEOUT != 0) &&
                   (tmo_q == TMO_LAST);
  assign state   = st_q;

  // Next-state selection from current state and sampled inputs.
  always_comb begin
    st_d = st_q;
    case (st_q)
      S_IDLE:   if (run) st_d = S_FETCH;
      S_FETCH:  st_d = S_DECODE;
      S_DECODE: begin
        case (dec_cls)
          IC_NOP:  st_d = S_FETCH;
          IC_HALT: st_d = S_HALT;
          default: st_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (cls_q)
          IC_ALU:   st_d = S_WB;
          IC_LOAD,
          IC_STORE: st_d = S_MEM;
          default:  st_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (mem_ready)
          st_d = (cls_q == IC_LOAD) ? S_WB : S_FETCH;
        else if (tmo_hit)
          st_d = S_FAULT;
      end
      S_WB:    st_d = S_FETCH;
      S_HALT:  if (run) st_d = S_FETCH;
      default: st_d = S_FAULT;
    endcase
  end

  // PC strobes depend on the inputs sampled in the current state.
  always_comb begin
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    case (st_q)
      S_DECODE: pc_inc = (dec_cls == IC_NOP);
      S_EXEC: begin
        if (cls_q == IC_BRANCH) begin
          pc_load = cond_true;
          pc_inc  = !cond_true;
        end
      end
      S_MEM:   pc_inc = mem_ready &&
                        (cls_q == IC_STORE);
      S_WB:    pc_inc = 1'b1;
      S_HALT:  pc_inc = run;
      default: ;
    endcase
  end

  // State, latched class, timeout and registered Moore strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= S_IDLE;
      cls_q      <= IC_NOP;
      tmo_q      <= '0;
      ir_load    <= 1'b0;
      reg_read   <= 1'b0;
      alu_enable <= 1'b0;
      reg_write  <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      halted     <= 1'b1;
      fault      <= 1'b0;
    end else begin
      st_q <= st_d;
      if (st_q == S_DECODE) cls_q <= dec_cls;
      if (st_q == S_MEM && !mem_ready)
        tmo_q <= tmo_q + CW'(1);
      else
        tmo_q <= '0;
      ir_load    <= (st_d == S_FETCH);
      reg_read   <= (st_d == S_DECODE) ||
                    (st_d == S_EXEC);
      alu_enable <= (st_d == S_EXEC);
      reg_write  <= (st_d == S_WB);
      mem_req    <= (st_d == S_MEM);
      mem_we     <= (st_d == S_MEM) &&
                    (cls_q == IC_STORE);
      halted     <= (st_d == S_IDLE) ||
                    (st_d == S_HALT);
      fault      <= (st_d == S_FAULT);
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic active;
  assign active = !(st_q inside
                    {S_IDLE, S_HALT, S_FAULT});

  seq_perf_cnt u_perf (
    .clk         (clk),
    .rst_n       (rst_n),
    .active      (active),
    .retire      (pc_inc | pc_load),
    .cycle_cnt   (cycle_cnt),
    .retired_cnt (retired_cnt)
  );
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: per-class cycle tables
// queued by the driver, compared by a negedge monitor.
module tb_cpu_sequencer;

  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [2:0] inst_class;
  logic       cond_true;
  logic       mem_ready;
  logic       ir_load, pc_inc, pc_load, reg_read;
  logic       alu_enable, reg_write, mem_req, mem_we;
  logic       halted, fault;
  logic [2:0] state;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cycle_cnt, retired_cnt;
  int unsigned m_cyc = 0, m_ret = 0;
`endif

  always #5 clk = ~clk;

  cpu_sequencer #(.MEM_TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .inst_class (inst_class),
    .cond_true  (cond_true),
    .mem_ready  (mem_ready),
    .ir_load    (ir_load),
    .pc_inc     (pc_inc),
    .pc_load    (pc_load),
    .reg_read   (reg_read),
    .alu_enable (alu_enable),
    .reg_write  (reg_write),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .halted     (halted),
    .fault      (fault),
    .state      (state)
`ifdef SEQ_PERF_CNT_EN
    ,
    .cycle_cnt   (cycle_cnt),
    .retired_cnt (retired_cnt)
`endif
  );

  localparam logic [9:0] IR  = 10'h200;
  localparam logic [9:0] PCI = 10'h100;
  localparam logic [9:0] PCL = 10'h080;
  localparam logic [9:0] RR  = 10'h040;
  localparam logic [9:0] ALU = 10'h020;
  localparam logic [9:0] RW  = 10'h010;
  localparam logic [9:0] REQ = 10'h008;
  localparam logic [9:0] WE  = 10'h004;
  localparam logic [9:0] HLT = 10'h002;
  localparam logic [9:0] FLT = 10'h001;
  localparam logic [9:0] NONE = 10'h000;

  logic [12:0] expq[$];
  int errors = 0;
  int checks = 0;

  function automatic logic [12:0] o(
    input int st, input logic [9:0] f);
    return {3'(st), f};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [2:0] rc();
    return 3'($urandom_range(0, 7));
  endfunction

  task automatic cyc(input logic r,
                     input logic [2:0] ic,
                     input logic ct,
                     input logic mr,
                     input logic [12:0] e);
    run = r;
    inst_class = ic;
    cond_true = ct;
    mem_ready = mr;
    expq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // One instruction from FETCH to its last cycle.
  task automatic inst(input int cls,
                      input logic cnd,
                      input int waits,
                      input bit stall);
    logic [9:0] we;
    we = (cls == 3) ? WE : NONE;
    cyc(rb(), rc(), rb(), rb(), o(1, IR));
    if (cls == 0 || cls >= 6) begin
      cyc(rb(), 3'(cls), rb(), rb(), o(2, RR | PCI));
      return;
    end
    cyc(rb(), 3'(cls), rb(), rb(), o(2, RR));
    if (cls == 5) return;
    if (cls == 4) begin
      cyc(rb(), rc(), cnd, rb(),
          o(3, RR | ALU | (cnd ? PCL : PCI)));
      return;
    end
    cyc(rb(), rc(), rb(), rb(), o(3, RR | ALU));
    if (cls == 1) begin
      cyc(rb(), rc(), rb(), rb(), o(5, RW | PCI));
      return;
    end
    for (int i = 0; i < waits; i++)
      cyc(rb(), rc(), rb(), 1'b0, o(4, REQ | we));
    if (stall) return;
    cyc(rb(), rc(), rb(), 1'b1,
        o(4, REQ | we | ((cls == 3) ? PCI : NONE)));
    if (cls == 2)
      cyc(rb(), rc(), rb(), rb(), o(5, RW | PCI));
  endtask

  task automatic halt_wait(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b0, rc(), rb(), rb(), o(6, HLT));
    cyc(1'b1, rc(), rb(), rb(), o(6, HLT | PCI));
  endtask

  task automatic idle_go(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b0, rc(), rb(), rb(), o(0, HLT));
    cyc(1'b1, rc(), rb(), rb(), o(0, HLT));
  endtask

  // Monitor: every cycle pops one expected observation.
  logic [12:0] act, exp_o;
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_o = expq.pop_front();
      act = {state, ir_load, pc_inc, pc_load,
             reg_read, alu_enable, reg_write,
             mem_req, mem_we, halted, fault};
      checks++;
      if (act !== exp_o) begin
        errors++;
        $display("FAIL strobes t=%0t got=%h want=%h",
                 $time, act, exp_o);
      end
`ifdef SEQ_PERF_CNT_EN
      if (!rst_n) begin
        m_cyc = 0;
        m_ret = 0;
      end
      checks++;
      if (cycle_cnt !== m_cyc ||
          retired_cnt !== m_ret) begin
        errors++;
        $display("FAIL perf t=%0t got=%0d/%0d want=%0d/%0d",
                 $time, cycle_cnt, retired_cnt,
                 m_cyc, m_ret);
      end
      if (rst_n) begin
        if (!(exp_o[12:10] inside {3'd0, 3'd6, 3'd7}))
          m_cyc++;
        if (exp_o[8] || exp_o[7]) m_ret++;
      end
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cls;
    rst_n = 1'b0;
    run = 1'b0;
    inst_class = 3'd0;
    cond_true = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      cyc(rb(), rc(), rb(), rb(), o(0, HLT));
    rst_n = 1'b1;
    idle_go(2);

    inst(1, 1'b0, 0, 1'b0);
    inst(4, 1'b1, 0, 1'b0);
    inst(4, 1'b0, 0, 1'b0);
    inst(2, 1'b0, 3, 1'b0);
    inst(3, 1'b0, 0, 1'b0);
    inst(2, 1'b0, 0, 1'b0);
    inst(3, 1'b0, TMO - 1, 1'b0);
    inst(5, 1'b0, 0, 1'b0);
    halt_wait(10);
    inst(0, 1'b0, 0, 1'b0);
    inst(6, 1'b0, 0, 1'b0);
    inst(7, 1'b0, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      cls = $urandom_range(0, 7);
      inst(cls, rb(), $urandom_range(0, TMO - 1),
           1'b0);
      if (cls == 5) halt_wait($urandom_range(0, 4));
    end

    inst(2, 1'b0, 2, 1'b1);
    rst_n = 1'b0;
    cyc(rb(), rc(), rb(), rb(), o(0, HLT));
    cyc(rb(), rc(), rb(), rb(), o(0, HLT));
    rst_n = 1'b1;
    idle_go(1);
    inst(1, 1'b0, 0, 1'b0);

    inst(3, 1'b0, TMO, 1'b1);
    for (int i = 0; i < 5; i++)
      cyc(rb(), rc(), rb(), rb(), o(7, FLT));
    rst_n = 1'b0;
    cyc(rb(), rc(), rb(), rb(), o(0, HLT));
    rst_n = 1'b1;
    idle_go(1);
    inst(4, 1'b1, 0, 1'b0);

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d want=0",
               expq.size());
    end
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
